gcn_accum_row_buffer: RTL and testbench

//  Parametrised accumulate-in-place row buffer for GCN aggregation (FM*WM*ADJ partial sums).

---
 rtl/gcn_acc_pkg.sv | 56 +++++
 rtl/gcn_acc_lane.sv | 40 ++++
 rtl/gcn_accum_row_buffer.sv | 167 ++++++++++++++++
 tb/tb_gcn_accum_row_buffer.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcn_acc_pkg.sv
// -----------------------------------------------------------------------------
// gcn_acc_pkg
// Shared types and helpers for the GCN accumulate-in-place row buffer.
//   state_e      : buffer FSM states (CLEAR sweep, ACTIVE operation)
//   sat_res_t    : result of one column add (wide sum plus clamp flag)
//   sat_add()    : signed add at a wide internal width, with optional clamp
//                  to the signed range of a DW-bit value
//   DW_DEFAULT   : default value width
//   COLS_DEFAULT : default number of columns per row
// -----------------------------------------------------------------------------
package gcn_acc_pkg;

  localparam int DW_DEFAULT   = 16;
  localparam int COLS_DEFAULT = 3;

  // Internal width of the add; wide enough for any DW the lane supports (< 64).
  localparam int ACC_W = 64;

  typedef enum logic {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic signed [ACC_W-1:0] sum;
    logic                    sat;
  } sat_res_t;

  // Operands arrive sign-extended from dw bits, so the wide sum is exact.
  // The caller keeps the low dw bits, which gives wrap-around when clamp=0.
  function automatic sat_res_t sat_add(input logic signed [ACC_W-1:0] a,
                                       input logic signed [ACC_W-1:0] b,
                                       input int unsigned             dw,
                                       input logic                    clamp);
    sat_res_t                res;
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    res.sum = s;
    res.sat = 1'b0;
    if (clamp) begin
      if (s > hi) begin
        res.sum = hi;
        res.sat = 1'b1;
      end else if (s < lo) begin
        res.sum = lo;
        res.sat = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gcn_acc_lane.sv
// -----------------------------------------------------------------------------
// gcn_acc_lane
// One column of the accumulate path: combinational signed add of the stored
// value and the addend, wrapping mod 2^DW or clamping when the build defines
// GCN_ACC_SATURATE_EN.
//   a_i   : current stored value (DW, signed)
//   b_i   : addend (DW, signed)
//   sum_o : new value to store (DW)
//   sat_o : 1 when the result was clamped (always 0 without the macro)
// -----------------------------------------------------------------------------
module gcn_acc_lane
  import gcn_acc_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic        [DW-1:0] sum_o,
  output logic                 sat_o
);

`ifdef GCN_ACC_SATURATE_EN
  localparam logic CLAMP = 1'b1;
`else
  localparam logic CLAMP = 1'b0;
`endif

  sat_res_t res;
  logic     unused_hi;

  always_comb begin
    res = sat_add(ACC_W'(a_i), ACC_W'(b_i), DW, CLAMP);
  end

  assign sum_o     = res.sum[DW-1:0];
  assign sat_o     = res.sat;
  // Upper bits of the wide sum only matter inside the clamp decision.
  assign unused_hi = ^res.sum[ACC_W-1:DW];

endmodule

// File: rtl/gcn_accum_row_buffer.sv
// -----------------------------------------------------------------------------
// gcn_accum_row_buffer
// Accumulate-in-place row buffer for GCN aggregation partial sums. Each
// accepted write adds a row vector into the addressed row; reads return a row
// one cycle later. A self-timed sweep zeroes every row after reset or clr_i.
// Optional saturation: define GCN_ACC_SATURATE_EN to clamp instead of wrap.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr_i               : restart the clear sweep; clears err_o and sat_o
//   busy_o              : high while the clear sweep runs
//   wr_valid/wr_ready   : write-accumulate handshake
//   wr_row, wr_data     : target row and addend vector [0:COLS-1]
//   rd_en, rd_row       : read request and row
//   rd_valid, rd_data   : registered read result
//   err_o               : sticky out-of-range row flag
//   sat_o               : sticky saturation flag
// -----------------------------------------------------------------------------
module gcn_accum_row_buffer
  import gcn_acc_pkg::*;
#(
  parameter  int ROWS = 6,
  parameter  int COLS = COLS_DEFAULT,
  parameter  int DW   = DW_DEFAULT,
  localparam int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  output logic          busy_o,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [RW-1:0] wr_row,
  input  logic [DW-1:0] wr_data [0:COLS-1],
  input  logic          rd_en,
  input  logic [RW-1:0] rd_row,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data [0:COLS-1],
  output logic          err_o,
  output logic          sat_o
);

  state_e        state_q, state_d;
  logic [RW-1:0] sweep_cnt_q, sweep_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q [0:COLS-1];
  logic [DW-1:0] rd_data_d [0:COLS-1];
  logic          err_q, err_d;
  logic          sat_q, sat_d;

  logic [DW-1:0] mem [0:ROWS-1][0:COLS-1];

  logic          wr_fire, rd_fire;
  logic          wr_in_range, rd_in_range;
  logic [RW-1:0] wr_idx;
  logic [DW-1:0] lane_sum [0:COLS-1];
  logic [COLS-1:0] lane_sat;

  assign wr_in_range = {1'b0, wr_row} < (RW+1)'(ROWS);
  assign rd_in_range = {1'b0, rd_row} < (RW+1)'(ROWS);
  // Keep the lane's memory operand in bounds; dropped writes ignore the sum.
  assign wr_idx      = wr_in_range ? wr_row : '0;
  assign wr_fire     = wr_valid && wr_ready;
  assign rd_fire     = rd_en && (state_q == ACTIVE);

  assign busy_o   = (state_q == CLEAR);
  assign wr_ready = (state_q == ACTIVE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err_o    = err_q;
  // Lanes never flag without clamping, so this stays 0 in the wrap build.
  assign sat_o    = sat_q;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    gcn_acc_lane #(.DW(DW)) u_lane (
      .a_i   (mem[wr_idx][c]),
      .b_i   (wr_data[c]),
      .sum_o (lane_sum[c]),
      .sat_o (lane_sat[c])
    );
  end

  // FSM and sweep counter: one row zeroed per CLEAR cycle; clr_i restarts.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_i) begin
          sweep_cnt_d = '0;
        end else if (sweep_cnt_q == RW'(ROWS - 1)) begin
          state_d     = ACTIVE;
          sweep_cnt_d = '0;
        end else begin
          sweep_cnt_d = sweep_cnt_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (clr_i) begin
          state_d     = CLEAR;
          sweep_cnt_d = '0;
        end
      end
      default: begin
        state_d     = CLEAR;
        sweep_cnt_d = '0;
      end
    endcase
  end

  // Read register and sticky flags. A fresh error/saturation event in the
  // clr_i cycle wins over the clear, since it happened after the clear request.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_data_d  = rd_data_q;
    err_d      = err_q;
    sat_d      = sat_q;
    if (rd_fire) begin
      for (int c = 0; c < COLS; c++) begin
        rd_data_d[c] = rd_in_range ? mem[rd_row][c] : '0;
      end
    end
    if (clr_i) begin
      err_d = 1'b0;
      sat_d = 1'b0;
    end
    if ((wr_fire && !wr_in_range) || (rd_fire && !rd_in_range)) begin
      err_d = 1'b1;
    end
    if (wr_fire && wr_in_range && (|lane_sat)) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      sweep_cnt_q <= '0;
      rd_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        rd_data_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      rd_valid_q  <= rd_valid_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Memory has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      for (int c = 0; c < COLS; c++) begin
        mem[sweep_cnt_q][c] <= '0;
      end
    end else if (wr_fire && wr_in_range) begin
      for (int c = 0; c < COLS; c++) begin
        mem[wr_row][c] <= lane_sum[c];
      end
    end
  end

endmodule

// File: tb/tb_gcn_accum_row_buffer.sv
// -----------------------------------------------------------------------------
// tb_gcn_accum_row_buffer
// Directed self-checking bench for gcn_accum_row_buffer (ROWS=6, COLS=3,
// DW=16). Expected saturation results follow GCN_ACC_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_gcn_accum_row_buffer;

  logic        clk;
  logic        rst_n;
  logic        clr_i;
  logic        busy_o;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_row;
  logic [15:0] wr_data [0:2];
  logic        rd_en;
  logic [2:0]  rd_row;
  logic        rd_valid;
  logic [15:0] rd_data [0:2];
  logic        err_o;
  logic        sat_o;

  int checks;
  int errors;

  gcn_accum_row_buffer #(.ROWS(6), .COLS(3), .DW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr_i),
    .busy_o   (busy_o),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .err_o    (err_o),
    .sat_o    (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    wr_data[0] = a;
    wr_data[1] = b;
    wr_data[2] = c;
  endtask

  // Counts consecutive busy samples starting now, bounded at 50 cycles.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_o && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    int n;
    logic [15:0] zero;
    zero = 16'd0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || err_o !== 1'b0 || sat_o !== 1'b0) begin
      $display("[TB] FAIL reset_flags: busy=%b ready=%b rvalid=%b err=%b sat=%b expected 1 0 0 0 0",
               busy_o, wr_ready, rd_valid, err_o, sat_o);
      errors++;
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (rd_data[c] !== zero) begin
        $display("[TB] FAIL reset_rd_data[%0d]: got %0d expected 0", c, rd_data[c]);
        errors++;
      end
    end
    step();
    rst_n = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 6) begin
      $display("[TB] FAIL reset_busy_cycles: got %0d expected 6", n);
      errors++;
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      $display("[TB] FAIL reset_ready_after_sweep: got %b expected 1", wr_ready);
      errors++;
    end
    for (int r = 0; r < 6; r++) begin
      rd_en  = 1'b1;
      rd_row = 3'(r);
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_data[0] !== zero || rd_data[1] !== zero || rd_data[2] !== zero) begin
        $display("[TB] FAIL reset_read_row%0d: valid=%b data={%0d,%0d,%0d} expected 1 {0,0,0}",
                 r, rd_valid, rd_data[0], rd_data[1], rd_data[2]);
        errors++;
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_accumulate();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_row   = 3'd2;
      set_wr(16'd1, 16'd2, 16'd3);
      step();
    end
    wr_valid = 1'b0;
    rd_en    = 1'b1;
    rd_row   = 3'd2;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data[0] !== 16'd3 || rd_data[1] !== 16'd6 || rd_data[2] !== 16'd9) begin
      $display("[TB] FAIL accum_row2: valid=%b data={%0d,%0d,%0d} expected 1 {3,6,9}",
               rd_valid, rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_data[0] !== 16'd3 || rd_data[1] !== 16'd6 || rd_data[2] !== 16'd9) begin
      $display("[TB] FAIL accum_hold: valid=%b data={%0d,%0d,%0d} expected 0 {3,6,9}",
               rd_valid, rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
  endtask

  task automatic test_same_cycle();
    wr_valid = 1'b1;
    wr_row   = 3'd4;
    set_wr(16'd5, 16'd5, 16'd5);
    rd_en    = 1'b1;
    rd_row   = 3'd4;
    step();
    wr_valid = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data[0] !== 16'd0 || rd_data[1] !== 16'd0 || rd_data[2] !== 16'd0) begin
      $display("[TB] FAIL same_cycle_old: valid=%b data={%0d,%0d,%0d} expected 1 {0,0,0}",
               rd_valid, rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data[0] !== 16'd5 || rd_data[1] !== 16'd5 || rd_data[2] !== 16'd5) begin
      $display("[TB] FAIL same_cycle_new: valid=%b data={%0d,%0d,%0d} expected 1 {5,5,5}",
               rd_valid, rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
  endtask

  task automatic test_out_of_range();
    int n;
    logic [15:0] exp_row [0:5][0:2];
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 3; c++) begin
        exp_row[r][c] = 16'd0;
      end
    end
    exp_row[2][0] = 16'd3; exp_row[2][1] = 16'd6; exp_row[2][2] = 16'd9;
    exp_row[4][0] = 16'd5; exp_row[4][1] = 16'd5; exp_row[4][2] = 16'd5;
    checks++;
    if (err_o !== 1'b0) begin
      $display("[TB] FAIL oor_err_before: got %b expected 0", err_o);
      errors++;
    end
    wr_valid = 1'b1;
    wr_row   = 3'd7;
    set_wr(16'd9, 16'd9, 16'd9);
    checks++;
    if (wr_ready !== 1'b1) begin
      $display("[TB] FAIL oor_ready: got %b expected 1", wr_ready);
      errors++;
    end
    step();
    wr_valid = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      $display("[TB] FAIL oor_err_set: got %b expected 1", err_o);
      errors++;
    end
    for (int r = 0; r < 6; r++) begin
      rd_en  = 1'b1;
      rd_row = 3'(r);
      step();
      checks++;
      if (rd_data[0] !== exp_row[r][0] || rd_data[1] !== exp_row[r][1] || rd_data[2] !== exp_row[r][2]) begin
        $display("[TB] FAIL oor_row%0d_unchanged: got {%0d,%0d,%0d} expected {%0d,%0d,%0d}",
                 r, rd_data[0], rd_data[1], rd_data[2], exp_row[r][0], exp_row[r][1], exp_row[r][2]);
        errors++;
      end
    end
    rd_row = 3'd6;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data[0] !== 16'd0 || rd_data[1] !== 16'd0 || rd_data[2] !== 16'd0) begin
      $display("[TB] FAIL oor_read_zero: valid=%b data={%0d,%0d,%0d} expected 1 {0,0,0}",
               rd_valid, rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b1) begin
      $display("[TB] FAIL oor_clr: err=%b busy=%b expected 0 1", err_o, busy_o);
      errors++;
    end
    count_busy(n);
    checks++;
    if (n !== 6) begin
      $display("[TB] FAIL oor_clr_busy_cycles: got %0d expected 6", n);
      errors++;
    end
    rd_en  = 1'b1;
    rd_row = 3'd2;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data[0] !== 16'd0 || rd_data[1] !== 16'd0 || rd_data[2] !== 16'd0) begin
      $display("[TB] FAIL oor_row2_cleared: got {%0d,%0d,%0d} expected {0,0,0}",
               rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
  endtask

  task automatic test_saturation();
    logic [15:0] e0, e1, e2;
    logic        esat;
`ifdef GCN_ACC_SATURATE_EN
    e0 = 16'h7FFF; e1 = 16'd101; e2 = 16'h8000; esat = 1'b1;
`else
    e0 = 16'h8000; e1 = 16'd101; e2 = 16'h7FFF; esat = 1'b0;
`endif
    wr_valid = 1'b1;
    wr_row   = 3'd0;
    set_wr(16'h7FFF, 16'd100, 16'h8000);
    step();
    checks++;
    if (sat_o !== 1'b0) begin
      $display("[TB] FAIL sat_no_overflow: got %b expected 0", sat_o);
      errors++;
    end
    set_wr(16'd1, 16'd1, 16'hFFFF);
    step();
    wr_valid = 1'b0;
    checks++;
    if (sat_o !== esat) begin
      $display("[TB] FAIL sat_flag: got %b expected %b", sat_o, esat);
      errors++;
    end
    rd_en  = 1'b1;
    rd_row = 3'd0;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data[0] !== e0 || rd_data[1] !== e1 || rd_data[2] !== e2) begin
      $display("[TB] FAIL sat_row0: got {%0d,%0d,%0d} expected {%0d,%0d,%0d}",
               $signed(rd_data[0]), $signed(rd_data[1]), $signed(rd_data[2]),
               $signed(e0), $signed(e1), $signed(e2));
      errors++;
    end
  endtask

  task automatic test_clear_restart();
    int n;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    checks++;
    if (sat_o !== 1'b0 || busy_o !== 1'b1) begin
      $display("[TB] FAIL restart_clr: sat=%b busy=%b expected 0 1", sat_o, busy_o);
      errors++;
    end
    rd_en  = 1'b1;
    rd_row = 3'd1;
    step();
    step();
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || busy_o !== 1'b1) begin
      $display("[TB] FAIL restart_read_in_clear: rvalid=%b busy=%b expected 0 1", rd_valid, busy_o);
      errors++;
    end
    clr_i    = 1'b1;
    wr_valid = 1'b1;
    wr_row   = 3'd1;
    set_wr(16'd7, 16'd7, 16'd7);
    checks++;
    if (wr_ready !== 1'b0) begin
      $display("[TB] FAIL restart_ready: got %b expected 0", wr_ready);
      errors++;
    end
    step();
    clr_i    = 1'b0;
    wr_valid = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 6) begin
      $display("[TB] FAIL restart_busy_cycles: got %0d expected 6", n);
      errors++;
    end
    rd_en  = 1'b1;
    rd_row = 3'd1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data[0] !== 16'd0 || rd_data[1] !== 16'd0 || rd_data[2] !== 16'd0) begin
      $display("[TB] FAIL restart_row1: valid=%b data={%0d,%0d,%0d} expected 1 {0,0,0}",
               rd_valid, rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    wr_valid = 1'b1;
    wr_row   = 3'd3;
    set_wr(16'd4, 16'd4, 16'd4);
    step();
    wr_valid = 1'b0;
    rd_en    = 1'b1;
    rd_row   = 3'd3;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data[0] !== 16'd4 || rd_data[1] !== 16'd4 || rd_data[2] !== 16'd4) begin
      $display("[TB] FAIL midreset_pre_read: got {%0d,%0d,%0d} expected {4,4,4}",
               rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b1 || rd_valid !== 1'b0 || rd_data[0] !== 16'd0 || wr_ready !== 1'b0) begin
      $display("[TB] FAIL midreset_state: busy=%b rvalid=%b data0=%0d ready=%b expected 1 0 0 0",
               busy_o, rd_valid, rd_data[0], wr_ready);
      errors++;
    end
    step();
    rst_n = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 6) begin
      $display("[TB] FAIL midreset_busy_cycles: got %0d expected 6", n);
      errors++;
    end
    rd_en  = 1'b1;
    rd_row = 3'd3;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_data[0] !== 16'd0 || rd_data[1] !== 16'd0 || rd_data[2] !== 16'd0) begin
      $display("[TB] FAIL midreset_row3: got {%0d,%0d,%0d} expected {0,0,0}",
               rd_data[0], rd_data[1], rd_data[2]);
      errors++;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    clr_i    = 1'b0;
    wr_valid = 1'b0;
    wr_row   = 3'd0;
    rd_en    = 1'b0;
    rd_row   = 3'd0;
    set_wr(16'd0, 16'd0, 16'd0);
    step();
    step();
    $display("[TB] reset");
    test_reset();
    $display("[TB] accumulate");
    test_accumulate();
    $display("[TB] same-cycle read/write");
    test_same_cycle();
    $display("[TB] out-of-range rows");
    test_out_of_range();
    $display("[TB] saturation / wrap");
    test_saturation();
    $display("[TB] clear restart");
    test_clear_restart();
    $display("[TB] mid-operation reset");
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
